// File: rtl/wrr_arbiter.sv
// wrr_arbiter: weighted round-robin arbiter with per-client burst credit and shared stall.
module wrr_arbiter #(
    parameter int CLIENTS  = 8,
    parameter int WEIGHT_W = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [CLIENTS-1:0]            request,
    input  logic [CLIENTS*WEIGHT_W-1:0]   weight,
    input  logic                          stall,
    output logic [CLIENTS-1:0]            grant,
    output logic                          grant_valid,
    output logic [$clog2(CLIENTS)-1:0]    grant_id
);
    localparam int IW = $clog2(CLIENTS);
    typedef enum logic {IDLE, BURST} state_t;
    state_t              state;
    logic [IW-1:0]       ptr, sel, idx;
    logic [WEIGHT_W-1:0] credit, sel_w;
    logic                found;
    // Scan downward so the lowest offset from ptr wins.
    always_comb begin
        found = 1'b0;
        sel   = ptr;
        idx   = '0;
        for (int k = CLIENTS - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % CLIENTS);
            if (request[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        sel_w = weight[int'(sel)*WEIGHT_W +: WEIGHT_W];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
            credit      <= '0;
        end else if (!stall) begin
            if (state == BURST && request[grant_id] && credit > WEIGHT_W'(1)) begin
                credit <= credit - 1'b1;
            end else if (found) begin
                state       <= BURST;
                grant       <= CLIENTS'(1) << sel;
                grant_valid <= 1'b1;
                grant_id    <= sel;
                ptr         <= (sel == IW'(CLIENTS - 1)) ? '0 : sel + 1'b1;
                credit      <= (sel_w == '0) ? WEIGHT_W'(1) : sel_w;
            end else begin
                state       <= IDLE;
                grant       <= '0;
                grant_valid <= 1'b0;
                grant_id    <= '0;
                credit      <= '0;
            end
        end
    end
endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Weighted round-robin arbiter that shares one resource among `CLIENTS` requesters. Each grant covers a burst of up to `weight` unstalled transfer cycles. A shared `stall` input freezes the current grant without consuming credit. It sits in front of the resource previously arbitrated by the plain round-robin arbiter, for traffic whose clients need unequal bandwidth shares and a bounded grant latency. Grant outputs are registered.

## Interface
Parameters:
- `CLIENTS`, default 8: number of requesters, ≥2.
- `WEIGHT_W`, default 3: width of each per-client weight field.

Ports (clock and reset first):
- `clock`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `request`  in  CLIENTS  per-client request.
- `weight`  in  CLIENTS*WEIGHT_W  per-client burst length; client i uses bits [i*WEIGHT_W +: WEIGHT_W]; quasi-static configuration.
- `stall`  in  1  resource busy; freezes the arbiter.
- `grant`  out  CLIENTS  one-hot or zero, registered.
- `grant_valid`  out  1  OR of `grant`, registered.
- `grant_id`  out  $clog2(CLIENTS)  index of the granted client; 0 when `grant_valid` is 0.

## Operation
- Internal state:
  - `owner` (index)
  - `credit` (WEIGHT_W bits)
  - `ptr` (index of the highest-priority client)
- States:
  - IDLE: `grant_valid`=0.
  - BURST: exactly one grant bit is set.
- Transfer cycle: `grant[owner] & request[owner] & ~stall`. Each transfer decrements `credit` by 1.
- Arbitration selects the first client with `request` high, searching from `ptr` upward with wrap modulo CLIENTS.
- Grant issue:
  - Loads `credit` = `weight[sel]`, with weight 0 treated as 1.
  - Sets `owner`=sel and `ptr`=(sel+1) mod CLIENTS.
  - `weight` is sampled only at grant issue; changes mid-burst have no effect until the next issue.
- IDLE transitions:
  - any `request` and `stall`=0 → BURST with the selected client.
  - `stall`=1 → remain IDLE; no grant is issued while stalled.
- BURST transitions:
  - `stall`=1 → hold `grant`, `credit` and `ptr` unchanged, regardless of `request`.
  - Transfer with `credit`>1 → stay with `owner`.
  - Transfer with `credit`==1 (burst exhausted) → re-arbitrate in the same edge, with no bubble. If `owner` is the only requester it is re-granted and `credit` reloads.
  - `request[owner]`=0 with `stall`=0 (early release) → re-arbitrate from `ptr`; go to IDLE if there are no requests.
- Requester contract: `request` is held until granted. A request dropped before grant is simply not considered.
- Fairness: with `stall`=0, a request held high receives `grant` within 1 + (CLIENTS−1)*(2^WEIGHT_W−1) cycles.
- Invariants:
  - `grant` has at most one bit set.
  - `grant_id` and `grant_valid` are always consistent with `grant`.

## Timing
- Reset values: `grant`=0, `grant_valid`=0, `grant_id`=0, `ptr`=0, `credit`=0, state IDLE.
- Reset asserted mid-burst clears all outputs at that edge. The first grant after reset uses `ptr`=0.
- Latency: a request that is high with the arbiter IDLE and `stall`=0 at edge t produces `grant` visible from t+1.
- Handover: the last transfer of one owner and the first grant cycle of the next owner are adjacent cycles.
- `stall` takes effect in the cycle it is sampled high. The frozen grant remains visible throughout the stall.
- Arithmetic: `credit` never underflows; the minimum loaded value is 1.
- `ptr` wraps from CLIENTS−1 to 0.

## Test plan
- Reset: hold `reset` for 2 cycles with all requests high → `grant`=0, `grant_valid`=0, `grant_id`=0. The first grant is to client 0 at the cycle after reset deasserts.
- All weights 1, all clients requesting, `stall`=0 → `grant_id` sequence 0,1,2,…,7,0, with `grant_valid` continuously 1.
- Clients 1 (weight 3) and 5 (weight 1) requesting, others idle → `grant_id` pattern 1,1,1,5,1,1,1,5, with no idle cycles.
- Client 2 (weight 2) granted; after one transfer, `stall`=1 for 4 cycles → `grant[2]` is held for the 4 stalled cycles, then one more transfer cycle follows, then the grant moves to the next requester.
- Client 3 (weight 4) alone requesting; it drops `request` after 2 transfers → `grant` clears the next cycle. A new request from client 0 is then granted 1 cycle after it rises.
- Weight 0 on client 6 with clients 6 and 7 requesting → alternating single-cycle grants 6,7,6,7. Over 10⁴ random cycles, check the fairness bound and that `grant` is always one-hot or zero.
